// File: rtl/mem_port_rr_arbiter.sv
// Round-robin arbiter sharing one memory/bus port among four requesters.
// A grant is held until the port signals done, or until a timeout forces its release.

module decoder_2_4 (
  input  logic [1:0] i_sel,
  output logic [3:0] o_onehot
);
  assign o_onehot = 4'b0001 << i_sel;
endmodule

module mem_port_rr_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       start,
  output logic       timeout_err,
  output logic       timeout_seen
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

  state_t          r_state;
  logic [3:0]      r_gnt;
  logic [1:0]      r_gnt_id;
  logic            r_start;
  logic            r_timeout_err;
  logic            r_timeout_seen;
  logic [1:0]      r_last;
  logic [TO_W-1:0] r_cnt;

  state_t          w_state_nxt;
  logic [3:0]      w_gnt_nxt;
  logic [1:0]      w_gnt_id_nxt;
  logic            w_start_nxt;
  logic            w_err_nxt;
  logic            w_seen_nxt;
  logic [1:0]      w_last_nxt;
  logic [TO_W-1:0] w_cnt_nxt;
  logic [1:0]      w_winner;
  logic [3:0]      w_win_onehot;

  // Walk from farthest to nearest so the requester right after r_last wins.
  always_comb begin
    w_winner = r_last;
    for (int unsigned k = 4; k >= 1; k--) begin
      if (req[r_last + 2'(k)]) w_winner = r_last + 2'(k);
    end
  end

  decoder_2_4 u_dec (
    .i_sel    (w_winner),
    .o_onehot (w_win_onehot)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_gnt_id_nxt = r_gnt_id;
    w_start_nxt  = 1'b0;
    w_err_nxt    = 1'b0;
    w_seen_nxt   = r_timeout_seen;
    w_last_nxt   = r_last;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_nxt  = S_BUSY;
          w_gnt_nxt    = w_win_onehot;
          w_gnt_id_nxt = w_winner;
          w_start_nxt  = 1'b1;
          w_cnt_nxt    = '0;
        end
      end
      S_BUSY: begin
        if (done) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = 4'b0000;
          w_last_nxt  = r_gnt_id;
        end else if (r_cnt >= CNT_LAST) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = 4'b0000;
          w_last_nxt  = r_gnt_id;
          w_err_nxt   = 1'b1;
          w_seen_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_state        <= S_IDLE;
      r_gnt          <= 4'b0000;
      r_gnt_id       <= 2'd0;
      r_start        <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_timeout_seen <= 1'b0;
      r_last         <= 2'd3;
      r_cnt          <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_gnt          <= w_gnt_nxt;
      r_gnt_id       <= w_gnt_id_nxt;
      r_start        <= w_start_nxt;
      r_timeout_err  <= w_err_nxt;
      r_timeout_seen <= w_seen_nxt;
      r_last         <= w_last_nxt;
      r_cnt          <= w_cnt_nxt;
    end
  end

  assign gnt          = r_gnt;
  assign gnt_id       = r_gnt_id;
  assign busy         = (r_state == S_BUSY);
  assign start        = r_start;
  assign timeout_err  = r_timeout_err;
  assign timeout_seen = r_timeout_seen;

endmodule

// File: tb/tb_mem_port_rr_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of owner, age and rotation.

module tb_mem_port_rr_arbiter;

  localparam int TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       start;
  logic       timeout_err;
  logic       timeout_seen;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_rr_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .done         (done),
    .gnt          (gnt),
    .gnt_id       (gnt_id),
    .busy         (busy),
    .start        (start),
    .timeout_err  (timeout_err),
    .timeout_seen (timeout_seen)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the port (-1 = nobody), how many cycles it has held it,
  // who was served last, and the error flags.
  int m_owner = -1;
  int m_age   = 0;
  int m_last  = 3;
  bit m_start = 0;
  bit m_err   = 0;
  bit m_seen  = 0;
  bit m_valid = 0;

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    m_valid = 1;
    m_start = 0;
    m_err   = 0;
    if (reset) begin
      m_owner = -1;
      m_age   = 0;
      m_last  = 3;
      m_seen  = 0;
    end else if (m_owner < 0) begin
      if (req != 4'b0000) begin
        m_owner = pick(req, m_last);
        m_age   = 1;
        m_start = 1;
      end
    end else if (done) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (m_age >= TIMEOUT) begin
      m_last  = m_owner;
      m_owner = -1;
      m_err   = 1;
      m_seen  = 1;
    end else begin
      m_age++;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (m_valid) begin
      check("model_gnt", gnt, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      check("model_busy", busy, (m_owner >= 0) ? 32'd1 : 32'd0);
      check("model_start", start, m_start);
      check("model_timeout_err", timeout_err, m_err);
      check("model_timeout_seen", timeout_seen, m_seen);
      check("gnt_onehot0", $onehot0(gnt), 1);
      if (m_owner >= 0) check("model_gnt_id", gnt_id, m_owner);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [3:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    reset = 1'b1;
    req   = 4'hF;
    done  = 1'b0;

    // Reset held with all requests asserted
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_gnt", gnt, 0);
      check("rst_busy", busy, 0);
      check("rst_start", start, 0);
      check("rst_seen", timeout_seen, 0);
    end
    reset = 1'b0;
    req   = 4'b0000;
    step();

    // Single requester
    req = 4'b0100;
    step();
    check("single_gnt", gnt, 4'b0100);
    check("single_id", gnt_id, 2);
    check("single_start", start, 1);
    step();
    check("single_start_drop", start, 0);
    check("single_hold", gnt, 4'b0100);
    done = 1'b1;
    step();
    check("single_release", gnt, 0);
    check("single_idle", busy, 0);
    done = 1'b0;

    // Rotation: 2 was last, so 3 beats 1
    req = 4'b1010;
    step();
    check("rot_gnt", gnt, 4'b1000);
    check("rot_id", gnt_id, 3);
    done = 1'b1;
    req  = 4'b0000;
    step();
    done = 1'b0;

    // Full contention: 0,1,2,3,0 with an idle cycle between grants
    req = 4'hF;
    for (int g = 0; g < 5; g++) begin
      step();
      check("cont_gnt", gnt, exp_order[g]);
      check("cont_start", start, 1);
      step();
      check("cont_hold", gnt, exp_order[g]);
      done = 1'b1;
      step();
      check("cont_gap", gnt, 0);
      done = 1'b0;
    end
    req = 4'b0000;

    // Timeout: held TIMEOUT cycles, then released with one error pulse
    req = 4'b0001;
    step();
    check("to_gnt", gnt, 4'b0001);
    for (int c = 1; c < TIMEOUT; c++) begin
      step();
      check("to_hold", gnt, 4'b0001);
      check("to_no_err", timeout_err, 0);
    end
    req = 4'b0000;
    step();
    check("to_release", gnt, 0);
    check("to_err", timeout_err, 1);
    check("to_seen", timeout_seen, 1);
    step();
    check("to_err_once", timeout_err, 0);
    check("to_seen_sticky", timeout_seen, 1);
    req = 4'b0100;
    step();
    check("to_next_gnt", gnt, 4'b0100);
    done = 1'b1;
    req  = 4'b0000;
    step();
    check("to_next_done", gnt, 0);
    check("to_next_no_err", timeout_err, 0);
    done = 1'b0;

    // done in the start cycle
    req = 4'b0001;
    step();
    check("early_gnt", gnt, 4'b0001);
    done = 1'b1;
    req  = 4'b0000;
    step();
    check("early_release", gnt, 0);
    done = 1'b0;

    // dropping req keeps the grant
    req = 4'b0010;
    step();
    check("drop_gnt", gnt, 4'b0010);
    req = 4'b0000;
    step();
    check("drop_hold1", gnt, 4'b0010);
    step();
    check("drop_hold2", gnt, 4'b0010);

    // reset while busy, priority restarts at 0
    reset = 1'b1;
    step();
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_seen", timeout_seen, 0);
    reset = 1'b0;
    req   = 4'hF;
    step();
    check("post_rst_gnt", gnt, 4'b0001);
    done = 1'b1;
    req  = 4'b0000;
    step();
    done = 1'b0;

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      req   = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      done  = ($urandom_range(0, 3) == 0);
      step();
    end

    reset = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
